// File: rtl/perceptron_feeder.sv
// Initiator for the perceptron: walks the pattern memory, drives each pattern, scores the result.
// Optional PERCEPTRON_FEEDER_STOP_ON_MISS_EN ends the pass at the first miss or timeout.
module perceptron_feeder #(
  parameter int unsigned WIDTH    = 25,
  parameter int unsigned SET_SIZE = 20,
  parameter int unsigned MIN_HOLD = 6,
  parameter int unsigned TIMEOUT  = 200,
  parameter int unsigned ACC_W    = $clog2(WIDTH),
  parameter int unsigned CNT_W    = $clog2(SET_SIZE + 1),
  localparam int unsigned AW      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH+1:0] mem_data,
  output logic [WIDTH-1:0] p_in,
  output logic             p_en,
  input  logic             p_ready,
  input  logic [1:0]       p_out,
  input  logic [ACC_W-1:0] p_acc,
  output logic             res_valid,
  output logic [AW-1:0]    res_idx,
  output logic [1:0]       res_out,
  output logic [ACC_W-1:0] res_acc,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned HOLD_MAX = (TIMEOUT > MIN_HOLD) ? TIMEOUT : MIN_HOLD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DRIVE, S_CAPTURE, S_GAP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [1:0]         exp_q, exp_d;
  logic               fail_q, fail_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   p_in_q, p_in_d;
  logic               p_en_q, p_en_d;
  logic               res_valid_q, res_valid_d;
  logic [AW-1:0]      res_idx_q, res_idx_d;
  logic [1:0]         res_out_q, res_out_d;
  logic [ACC_W-1:0]   res_acc_q, res_acc_d;
  logic [CNT_W-1:0]   match_q, match_d, miss_q, miss_d, tmo_q, tmo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic accept_c, timeout_c, last_c;

  assign accept_c  = p_ready && (hold_q >= HOLD_W'(MIN_HOLD));
  assign timeout_c = !accept_c && (hold_q == HOLD_W'(TIMEOUT));
  assign last_c    = (idx_q == AW'(SET_SIZE - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH;
      S_FETCH:        state_d = S_LOAD;
      S_LOAD:         state_d = S_DRIVE;
      S_DRIVE:        if (accept_c || timeout_c) state_d = S_CAPTURE;
`ifdef PERCEPTRON_FEEDER_STOP_ON_MISS_EN
      S_CAPTURE:      state_d = fail_q ? S_DONE : S_GAP;
`else
      S_CAPTURE:      state_d = S_GAP;
`endif
      S_GAP:          state_d = last_c ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything lands in registers
  always_comb begin
    idx_d       = idx_q;
    hold_d      = hold_q;
    exp_d       = exp_q;
    fail_d      = fail_q;
    mem_addr_d  = mem_addr_q;
    p_in_d      = p_in_q;
    p_en_d      = p_en_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_out_d   = res_out_q;
    res_acc_d   = res_acc_q;
    match_d     = match_q;
    miss_d      = miss_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d      = '0;
          mem_addr_d = '0;
          match_d    = '0;
          miss_d     = '0;
          tmo_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_LOAD: begin
        p_in_d = mem_data[WIDTH-1:0];
        exp_d  = mem_data[WIDTH+1:WIDTH];
        p_en_d = 1'b1;
        hold_d = '0;
      end
      S_DRIVE: begin
        if (hold_q != HOLD_W'(HOLD_MAX)) hold_d = hold_q + HOLD_W'(1);
        if (accept_c || timeout_c) begin
          p_en_d      = 1'b0;
          res_valid_d = 1'b1;
          res_idx_d   = idx_q;
          if (accept_c) begin
            res_out_d = p_out;
            res_acc_d = p_acc;
            fail_d    = (p_out != exp_q);
            if (p_out == exp_q) begin
              if (match_q != CNT_MAX) match_d = match_q + CNT_W'(1);
            end else begin
              if (miss_q != CNT_MAX) miss_d = miss_q + CNT_W'(1);
            end
          end else begin
            res_out_d = '0;
            res_acc_d = '0;
            fail_d    = 1'b1;
            if (tmo_q != CNT_MAX) tmo_d = tmo_q + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
`ifdef PERCEPTRON_FEEDER_STOP_ON_MISS_EN
        if (fail_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (last_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d      = idx_q + AW'(1);
          mem_addr_d = idx_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; p_en falls with rst asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      hold_q      <= '0;
      exp_q       <= '0;
      fail_q      <= 1'b0;
      mem_addr_q  <= '0;
      p_in_q      <= '0;
      p_en_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_out_q   <= '0;
      res_acc_q   <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      exp_q       <= exp_d;
      fail_q      <= fail_d;
      mem_addr_q  <= mem_addr_d;
      p_in_q      <= p_in_d;
      p_en_q      <= p_en_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_out_q   <= res_out_d;
      res_acc_q   <= res_acc_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign p_in      = p_in_q;
  assign p_en      = p_en_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_out   = res_out_q;
  assign res_acc   = res_acc_q;
  assign match_cnt = match_q;
  assign miss_cnt  = miss_q;
  assign tmo_cnt   = tmo_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_perceptron_feeder.sv
// Directed bench for perceptron_feeder: two-pattern set, behavioural perceptron with programmable ready.
module tb_perceptron_feeder;

  localparam int unsigned WIDTH = 25, SET_SIZE = 2, MIN_HOLD = 6, TIMEOUT = 20;
  localparam int unsigned ACC_W = 5, CNT_W = 2, AW = 1;
  localparam logic [WIDTH-1:0] CROSS  = 25'b10001_01010_00100_01010_10001;
  localparam logic [WIDTH-1:0] CIRCLE = 25'b01110_10001_10001_10001_01110;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] mem_addr;
  logic [WIDTH+1:0] mem_data;
  logic [WIDTH-1:0] p_in;
  logic p_en, p_ready;
  logic [1:0] p_out;
  logic [ACC_W-1:0] p_acc;
  logic res_valid;
  logic [AW-1:0] res_idx;
  logic [1:0] res_out;
  logic [ACC_W-1:0] res_acc;
  logic [CNT_W-1:0] match_cnt, miss_cnt, tmo_cnt;
  logic busy, done;

  int vecs = 0, errs = 0;

  perceptron_feeder #(.WIDTH(WIDTH), .SET_SIZE(SET_SIZE), .MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT),
                      .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .p_in(p_in), .p_en(p_en), .p_ready(p_ready), .p_out(p_out), .p_acc(p_acc),
    .res_valid(res_valid), .res_idx(res_idx), .res_out(res_out), .res_acc(res_acc),
    .match_cnt(match_cnt), .miss_cnt(miss_cnt), .tmo_cnt(tmo_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pattern memory (1-cycle read) and perceptron model keyed on cycles since p_en rose
  logic [WIDTH+1:0] mem [SET_SIZE];
  logic [1:0] ans [SET_SIZE];
  logic [ACC_W-1:0] accv [SET_SIZE];
  int rdy_a = -1, rdy_b = -1;
  int hcnt = 0;

  always @(posedge clk) mem_data <= mem[mem_addr];
  always @(posedge clk) if (!p_en) hcnt <= 0; else hcnt <= hcnt + 1;
  assign p_ready = p_en && (hcnt == rdy_a || hcnt == rdy_b);
  assign p_out   = ans[mem_addr];
  assign p_acc   = accv[mem_addr];

  int n_res, first_c, done_c;
  logic [AW-1:0] got_idx [4];
  logic [1:0] got_out [4];
  logic [ACC_W-1:0] got_acc [4];
  logic [WIDTH-1:0] got_pin [4];

  task automatic load_set(input logic [1:0] a0, input logic [1:0] a1, input int ra, input int rb);
    mem[0] = {2'b11, CROSS};
    mem[1] = {2'b10, CIRCLE};
    ans[0] = a0; ans[1] = a1;
    accv[0] = 5'd17; accv[1] = 5'd3;
    rdy_a = ra; rdy_b = rb;
  endtask

  // Start a pass, log res_valid pulses, stop when done rises; again_c>0 pulses start mid-pass
  task automatic run_pass(input int again_c);
    n_res = 0; first_c = -1; done_c = -1;
    for (int i = 0; i < 4; i++) begin
      got_idx[i] = 'x; got_out[i] = 'x; got_acc[i] = 'x; got_pin[i] = 'x;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = (c == again_c);
      if (res_valid) begin
        if (n_res < 4) begin
          got_idx[n_res] = res_idx; got_out[n_res] = res_out;
          got_acc[n_res] = res_acc; got_pin[n_res] = p_in;
        end
        if (first_c < 0) first_c = c;
        n_res++;
      end
      if (done) begin done_c = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    load_set(2'b11, 2'b10, -1, -1);
    #23;
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    if (p_en !== 1'b0) begin errs++; $display("FAIL reset p_en: got %b want 0", p_en); end vecs++;
    if (mem_addr !== '0) begin errs++; $display("FAIL reset mem_addr: got %0d want 0", mem_addr); end vecs++;
    if (p_in !== '0) begin errs++; $display("FAIL reset p_in: got %h want 0", p_in); end vecs++;
    if ({res_valid, res_idx, res_out, res_acc} !== '0) begin errs++;
      $display("FAIL reset res: got %b/%0d/%b/%0d want all 0", res_valid, res_idx, res_out, res_acc); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt} !== '0) begin errs++;
      $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", match_cnt, miss_cnt, tmo_cnt); end vecs++;
    if ({busy, done} !== 2'b00) begin errs++; $display("FAIL reset busy/done: got %b%b want 00", busy, done); end vecs++;
  endtask

  task automatic test_match_pass();
    load_set(2'b11, 2'b10, 8, -1);
    run_pass(0);
    if (first_c !== 11) begin errs++; $display("FAIL match latency: got %0d want 11", first_c); end vecs++;
    if (n_res !== 2) begin errs++; $display("FAIL match pulses: got %0d want 2", n_res); end vecs++;
    if (got_idx[0] !== 1'b0 || got_idx[1] !== 1'b1) begin errs++;
      $display("FAIL match idx: got %0d,%0d want 0,1", got_idx[0], got_idx[1]); end vecs++;
    if (got_out[0] !== 2'b11 || got_out[1] !== 2'b10) begin errs++;
      $display("FAIL match res_out: got %b,%b want 11,10", got_out[0], got_out[1]); end vecs++;
    if (got_acc[0] !== 5'd17 || got_acc[1] !== 5'd3) begin errs++;
      $display("FAIL match res_acc: got %0d,%0d want 17,3", got_acc[0], got_acc[1]); end vecs++;
    if (got_pin[0] !== CROSS || got_pin[1] !== CIRCLE) begin errs++;
      $display("FAIL match p_in: got %h,%h want %h,%h", got_pin[0], got_pin[1], CROSS, CIRCLE); end vecs++;
    if (done_c !== 26) begin errs++; $display("FAIL match done cycle: got %0d want 26", done_c); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt} !== {2'd2, 2'd0, 2'd0}) begin errs++;
      $display("FAIL match counters: got %0d/%0d/%0d want 2/0/0", match_cnt, miss_cnt, tmo_cnt); end vecs++;
    if ({busy, done} !== 2'b01) begin errs++; $display("FAIL match busy/done: got %b%b want 01", busy, done); end vecs++;
  endtask

  task automatic test_early_ready();
    load_set(2'b11, 2'b10, 2, 6);
    run_pass(0);
    if (first_c !== 9) begin errs++; $display("FAIL early capture cycle: got %0d want 9", first_c); end vecs++;
    if (n_res !== 2) begin errs++; $display("FAIL early pulses: got %0d want 2", n_res); end vecs++;
    if (done_c !== 22) begin errs++; $display("FAIL early done cycle: got %0d want 22", done_c); end vecs++;
    if (match_cnt !== 2'd2) begin errs++; $display("FAIL early match_cnt: got %0d want 2", match_cnt); end vecs++;
  endtask

  task automatic test_timeout();
    load_set(2'b11, 2'b10, -1, -1);
    run_pass(0);
    if (first_c !== 23) begin errs++; $display("FAIL tmo first cycle: got %0d want 23", first_c); end vecs++;
    if (n_res !== 2) begin errs++; $display("FAIL tmo pulses: got %0d want 2", n_res); end vecs++;
    if (got_out[0] !== 2'b00 || got_out[1] !== 2'b00) begin errs++;
      $display("FAIL tmo res_out: got %b,%b want 00,00", got_out[0], got_out[1]); end vecs++;
    if (got_acc[0] !== '0 || got_acc[1] !== '0) begin errs++;
      $display("FAIL tmo res_acc: got %0d,%0d want 0,0", got_acc[0], got_acc[1]); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt} !== {2'd0, 2'd0, 2'd2}) begin errs++;
      $display("FAIL tmo counters: got %0d/%0d/%0d want 0/0/2", match_cnt, miss_cnt, tmo_cnt); end vecs++;
    if (done_c !== 50) begin errs++; $display("FAIL tmo done cycle: got %0d want 50", done_c); end vecs++;
  endtask

  task automatic test_miss();
    load_set(2'b10, 2'b10, 6, -1);
    run_pass(0);
    if (got_out[0] !== 2'b10) begin errs++; $display("FAIL miss res_out: got %b want 10", got_out[0]); end vecs++;
`ifdef PERCEPTRON_FEEDER_STOP_ON_MISS_EN
    if (n_res !== 1) begin errs++; $display("FAIL miss pulses: got %0d want 1", n_res); end vecs++;
    if (done_c !== 10) begin errs++; $display("FAIL miss done cycle: got %0d want 10", done_c); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt} !== {2'd0, 2'd1, 2'd0}) begin errs++;
      $display("FAIL miss counters: got %0d/%0d/%0d want 0/1/0", match_cnt, miss_cnt, tmo_cnt); end vecs++;
`else
    if (n_res !== 2) begin errs++; $display("FAIL miss pulses: got %0d want 2", n_res); end vecs++;
    if (done_c !== 22) begin errs++; $display("FAIL miss done cycle: got %0d want 22", done_c); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt} !== {2'd1, 2'd1, 2'd0}) begin errs++;
      $display("FAIL miss counters: got %0d/%0d/%0d want 1/1/0", match_cnt, miss_cnt, tmo_cnt); end vecs++;
`endif
  endtask

  task automatic test_start_ignored();
    load_set(2'b11, 2'b10, 8, -1);
    run_pass(15);
    if (n_res !== 2) begin errs++; $display("FAIL restart pulses: got %0d want 2", n_res); end vecs++;
    if (done_c !== 26) begin errs++; $display("FAIL restart done cycle: got %0d want 26", done_c); end vecs++;
    if (match_cnt !== 2'd2) begin errs++; $display("FAIL restart match_cnt: got %0d want 2", match_cnt); end vecs++;
  endtask

  task automatic test_rst_mid_drive();
    int rv;
    load_set(2'b11, 2'b10, 8, -1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    if (p_en !== 1'b1 || match_cnt !== 2'd1 || busy !== 1'b1) begin errs++;
      $display("FAIL pre-rst state: got p_en=%b match=%0d busy=%b want 1/1/1", p_en, match_cnt, busy); end vecs++;
    #2 rst = 1'b1;
    #1;
    if (p_en !== 1'b0) begin errs++; $display("FAIL rst p_en: got %b want 0", p_en); end vecs++;
    if ({match_cnt, miss_cnt, tmo_cnt, busy, done} !== '0) begin errs++;
      $display("FAIL rst state: got %0d/%0d/%0d busy=%b done=%b want zeros", match_cnt, miss_cnt, tmo_cnt, busy, done); end vecs++;
    @(negedge clk) rst = 1'b0;
    rv = 0;
    repeat (30) begin @(negedge clk); if (res_valid) rv++; end
    if (rv !== 0 || busy !== 1'b0) begin errs++;
      $display("FAIL post-rst: got res_valid pulses=%0d busy=%b want 0/0", rv, busy); end vecs++;
  endtask

  initial begin
    test_reset();
    test_match_pass();
    test_early_ready();
    test_timeout();
    test_miss();
    test_start_ignored();
    test_rst_mid_drive();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
